thread_dispatcher: RTL and testbench
====================================

Name: thread_dispatcher

Overview:
- Initiator side of the per-core thread start/done interface: accepts job requests from the host/control path and launches them on idle hardware threads of one core.
- Drives `start_thread`, `debug_on` and `debug_commands` into the core. Consumes the core's `thread_busy` and `thread_done`.
- Tracks per-thread run state, enforces a completion timeout, and counts finished jobs.
- Sits between the host control registers and each core instance.

Parameters:
- NUM_THREADS_PER_CORE, 4, number of hardware threads driven (one bit per thread on every vector port)
- TIMEOUT_CYCLES, 1000, cycles from launch to completion before a thread is declared hung; must be less than 2^TMO_WIDTH
- TMO_WIDTH, 16, width of each per-thread timeout counter
- DBG_HOLD, 2, cycles each debug_commands pulse is held high

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  dispatch enable; when low, no new jobs are accepted
- job_valid  in  1  host has a job to launch
- job_ready  out  1  dispatcher can accept a job this cycle
- launch_tid  out  log2(NUM_THREADS_PER_CORE)  thread index assigned to the job accepted this cycle
- start_thread  out  NUM_THREADS_PER_CORE  one-cycle launch pulse per thread, to the core
- thread_busy  in  NUM_THREADS_PER_CORE  core thread running (registered in the core)
- thread_done  in  NUM_THREADS_PER_CORE  core thread finished (one-cycle pulse)
- dbg_mode  in  1  host debug mode request
- debug_on  out  1  registered copy of dbg_mode, to the core
- debug_step  in  NUM_THREADS_PER_CORE  host single-step request per thread (pulse)
- debug_commands  out  NUM_THREADS_PER_CORE  manual-completion command level, to the core
- thread_active  out  NUM_THREADS_PER_CORE  thread not IDLE in the dispatcher
- done_count  out  16  saturating count of completed jobs
- timeout_err  out  NUM_THREADS_PER_CORE  sticky per-thread timeout flag
- err_clear  in  1  clears all timeout_err bits

Behaviour:

Reset values:
- All outputs are 0.
- All thread FSMs are in IDLE and all counters are 0.
- Reset asserted mid-operation aborts every in-flight job immediately. No done_count increment and no error flag result from that abort.

Job acceptance:
- job_ready = en AND (any thread in IDLE). It is combinational from registered state.
- A job is accepted on a cycle where job_valid AND job_ready.
- At most one job is accepted per cycle.
- The job goes to the lowest-index IDLE thread. launch_tid shows that index in the same cycle and is 0 when no job is accepted.

Per-thread FSM (states IDLE, LAUNCH, WAIT_ACK, RUN):
- IDLE -> LAUNCH when this thread is selected at acceptance.
- LAUNCH: lasts exactly 1 cycle.
  - start_thread[i] = 1 in this cycle only; the output is registered.
  - The timeout counter clears to 0.
  - -> WAIT_ACK.
- WAIT_ACK:
  - thread_busy[i] = 1 -> RUN.
  - thread_done[i] = 1 -> IDLE with completion.
- RUN:
  - thread_done[i] = 1 -> IDLE with completion.
- Completion: done_count increments by 1 and saturates at 16'hFFFF.
- Simultaneous completions on multiple threads in one cycle add their popcount to done_count, still saturating.
- Timeout counter:
  - Increments every cycle in WAIT_ACK and RUN.
  - On reaching TIMEOUT_CYCLES: set timeout_err[i] and go to IDLE, with no done_count change.
  - If done and timeout occur in the same cycle, done wins and the error is not set.
- thread_active[i] = 1 whenever the thread is not IDLE.
- thread_done[i] seen while the thread is in IDLE or LAUNCH is ignored.

en behaviour:
- en low blocks new acceptances only.
- Threads already launched continue to completion or timeout.

Error clearing:
- err_clear clears all timeout_err bits.
- If err_clear and a new timeout on thread i occur in the same cycle, the set wins for bit i.

Debug path:
- debug_on follows dbg_mode with a 1-cycle register delay.
- debug_step[i] in any cycle where debug_commands[i] = 0 and the hold counter is 0: debug_commands[i] goes to 1 on the next cycle, stays 1 for exactly DBG_HOLD cycles, then returns to 0.
- debug_step[i] pulses arriving while debug_commands[i] = 1 are dropped.
- A minimum of 1 low cycle follows each pulse before the next pulse can start.
- The debug path runs independently of dbg_mode.

Test Plan:
1. Launch handshake: reset, en=1, job_valid for 1 cycle at T.
   - job_ready=1 and launch_tid=0 at T; start_thread=4'b0001 at T+1 only; thread_active[0]=1.
   - Drive thread_busy[0]=1 at T+2 and a thread_done[0] pulse at T+10 -> done_count=1 and thread_active[0]=0 at T+11.
2. Fill and stall: job_valid held high for 5 cycles.
   - Threads 0,1,2,3 are launched on consecutive cycles; job_ready=0 on the 5th cycle.
   - A done on thread 2 reopens job_ready, and the next job gets launch_tid=2.
3. Timeout: launch thread 0 with TIMEOUT_CYCLES=1000 and never assert thread_done.
   - timeout_err=4'b0001 and the thread returns to IDLE after 1000 cycles in WAIT_ACK/RUN; done_count is unchanged.
   - err_clear clears the flag.
4. Same-cycle events:
   - thread_done coincides with the timeout cycle -> done_count increments and timeout_err stays 0.
   - Threads 1 and 3 done in the same cycle -> done_count increases by 2.
5. Debug pulses: debug_step[1] pulse -> debug_commands[1] high for exactly 2 cycles.
   - A second debug_step[1] during the high window is ignored.
   - dbg_mode=1 -> debug_on=1 one cycle later.
6. Reset and enable corners:
   - Assert reset while 3 threads are in RUN -> next cycle all outputs are 0, job_ready=en, and done_count=0.
   - en=0 with job_valid=1 -> no start_thread pulses at all.

Source files
------------

// File: rtl/thread_dispatcher.sv
// thread_dispatcher: launches host jobs on idle hardware threads of one core and tracks
// per-thread completion, timeouts, finished-job count and single-step debug pulses.
module thread_dispatcher #(
    parameter int NUM_THREADS_PER_CORE = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMO_WIDTH = 16,
    parameter int DBG_HOLD = 2,
    localparam int N = NUM_THREADS_PER_CORE,
    localparam int TID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             job_valid,
    output logic             job_ready,
    output logic [TID_W-1:0] launch_tid,
    output logic [N-1:0]     start_thread,
    input  logic [N-1:0]     thread_busy,
    input  logic [N-1:0]     thread_done,
    input  logic             dbg_mode,
    output logic             debug_on,
    input  logic [N-1:0]     debug_step,
    output logic [N-1:0]     debug_commands,
    output logic [N-1:0]     thread_active,
    output logic [15:0]      done_count,
    output logic [N-1:0]     timeout_err,
    input  logic             err_clear
);
    localparam int HW = (DBG_HOLD > 1) ? $clog2(DBG_HOLD + 1) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, RUN} state_t;

    state_t               state_q [N];
    state_t               state_d [N];
    logic [TMO_WIDTH-1:0] tmo_q [N];
    logic [TMO_WIDTH-1:0] tmo_d [N];
    logic [HW-1:0]        hold_q [N];
    logic [HW-1:0]        hold_d [N];
    logic [N-1:0]         start_q, start_d;
    logic [N-1:0]         err_q, err_d;
    logic [N-1:0]         dbg_cmd_q, dbg_cmd_d;
    logic [15:0]          done_count_q, done_count_d;
    logic                 debug_on_q;
    logic [N-1:0]         idle, run, cpl, tmo_fire, pick;
    logic [TID_W-1:0]     sel;
    logic                 accept;
    logic [16:0]          cpl_sum;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                tmo_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            start_q      <= '0;
            err_q        <= '0;
            dbg_cmd_q    <= '0;
            done_count_q <= '0;
            debug_on_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                tmo_q[i]   <= tmo_d[i];
                hold_q[i]  <= hold_d[i];
            end
            start_q      <= start_d;
            err_q        <= err_d;
            dbg_cmd_q    <= dbg_cmd_d;
            done_count_q <= done_count_d;
            debug_on_q   <= dbg_mode;
        end
    end

    // Per-thread events and lowest-index idle selection
    always_comb begin
        idle     = '0;
        run      = '0;
        cpl      = '0;
        tmo_fire = '0;
        sel      = '0;
        pick     = '0;
        for (int i = 0; i < N; i++) begin
            idle[i]     = state_q[i] == IDLE;
            run[i]      = state_q[i] == WAIT_ACK || state_q[i] == RUN;
            cpl[i]      = run[i] & thread_done[i];
            // a completion in the timeout cycle takes precedence over the error
            tmo_fire[i] = run[i] & ~thread_done[i] & (tmo_q[i] == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
        end
        for (int i = N - 1; i >= 0; i--)
            if (idle[i]) sel = TID_W'(i);
        accept    = job_valid & job_ready;
        pick[sel] = accept;
    end

    assign job_ready = en & |idle;

    // Next-state logic
    always_comb begin
        for (int i = 0; i < N; i++) begin
            case (state_q[i])
                IDLE:     state_d[i] = pick[i] ? LAUNCH : IDLE;
                LAUNCH:   state_d[i] = WAIT_ACK;
                WAIT_ACK: state_d[i] = (cpl[i] | tmo_fire[i]) ? IDLE : thread_busy[i] ? RUN : WAIT_ACK;
                RUN:      state_d[i] = (cpl[i] | tmo_fire[i]) ? IDLE : RUN;
                default:  state_d[i] = IDLE;
            endcase
        end
    end

    // Output and datapath logic
    always_comb begin
        cpl_sum = {1'b0, done_count_q};
        for (int i = 0; i < N; i++) begin
            start_d[i]   = pick[i];
            tmo_d[i]     = state_q[i] == LAUNCH ? '0 : run[i] ? tmo_q[i] + TMO_WIDTH'(1) : tmo_q[i];
            cpl_sum      = cpl_sum + 17'(cpl[i]);
            // hold_q counts remaining high cycles; the forced low cycle comes from requiring cmd low to retrigger
            dbg_cmd_d[i] = dbg_cmd_q[i] ? hold_q[i] != '0 : debug_step[i];
            hold_d[i]    = dbg_cmd_q[i] ? (hold_q[i] != '0 ? hold_q[i] - HW'(1) : '0)
                                        : (debug_step[i] ? HW'(DBG_HOLD - 1) : '0);
        end
        done_count_d = cpl_sum[16] ? 16'hFFFF : cpl_sum[15:0];
        err_d        = (err_q & ~{N{err_clear}}) | tmo_fire;
        launch_tid   = accept ? sel : '0;
    end

    assign start_thread   = start_q;
    assign thread_active  = ~idle;
    assign done_count     = done_count_q;
    assign timeout_err    = err_q;
    assign debug_on       = debug_on_q;
    assign debug_commands = dbg_cmd_q;

endmodule

// File: tb/tb_thread_dispatcher.sv
// tb_thread_dispatcher: directed plus randomized stimulus checked every cycle against a
// time-based reference model of job launches, completions, timeouts and debug pulses.
module tb_thread_dispatcher;
    localparam int N = 4;
    localparam int T = 1000;
    localparam int H = 2;

    logic         clk = 1'b0;
    logic         reset, en, job_valid, dbg_mode, err_clear;
    logic         job_ready, debug_on;
    logic [1:0]   launch_tid;
    logic [N-1:0] start_thread, thread_busy, thread_done, debug_step, debug_commands;
    logic [N-1:0] thread_active, timeout_err;
    logic [15:0]  done_count;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: a job is identified by the cycle it was accepted in
    bit         live [N];
    int         acc_at [N];
    bit [N-1:0] m_err;
    int         m_cnt;
    int         dbg_s [N];
    bit         m_dbgon;
    int         cyc = 0;
    int         done_div;

    thread_dispatcher #(
        .NUM_THREADS_PER_CORE(N),
        .TIMEOUT_CYCLES(T),
        .TMO_WIDTH(16),
        .DBG_HOLD(H)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .launch_tid(launch_tid),
        .start_thread(start_thread),
        .thread_busy(thread_busy),
        .thread_done(thread_done),
        .dbg_mode(dbg_mode),
        .debug_on(debug_on),
        .debug_step(debug_step),
        .debug_commands(debug_commands),
        .thread_active(thread_active),
        .done_count(done_count),
        .timeout_err(timeout_err),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, o, e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            live[i]   = 1'b0;
            acc_at[i] = -100;
            dbg_s[i]  = -100;
        end
        m_err   = '0;
        m_cnt   = 0;
        m_dbgon = 1'b0;
    endtask

    // Check all outputs at the falling edge, then advance the model across the rising edge
    task automatic tick();
        logic [N-1:0] e_start, e_act, e_dbg, fired;
        int tid, c;
        bit rdy, acc;
        @(negedge clk);
        tid = -1;
        for (int i = N - 1; i >= 0; i--)
            if (!live[i]) tid = i;
        rdy = en && tid >= 0;
        acc = rdy && job_valid;
        for (int i = 0; i < N; i++) begin
            e_start[i] = live[i] && acc_at[i] == cyc - 1;
            e_act[i]   = live[i];
            e_dbg[i]   = cyc >= dbg_s[i] && cyc < dbg_s[i] + H;
        end
        chk("job_ready", job_ready, rdy);
        chk("launch_tid", launch_tid, acc ? tid : 0);
        chk("start_thread", start_thread, e_start);
        chk("thread_active", thread_active, e_act);
        chk("done_count", done_count, m_cnt);
        chk("timeout_err", timeout_err, m_err);
        chk("debug_on", debug_on, m_dbgon);
        chk("debug_commands", debug_commands, e_dbg);
        if (reset) model_clear();
        else begin
            c = 0;
            fired = '0;
            for (int i = 0; i < N; i++)
                if (live[i] && cyc >= acc_at[i] + 2) begin
                    if (thread_done[i]) begin
                        c++;
                        live[i] = 1'b0;
                    end else if (cyc == acc_at[i] + T + 1) begin
                        fired[i] = 1'b1;
                        live[i]  = 1'b0;
                    end
                end
            if (acc) begin
                live[tid]   = 1'b1;
                acc_at[tid] = cyc;
            end
            m_err = (err_clear ? '0 : m_err) | fired;
            m_cnt = (m_cnt + c > 65535) ? 65535 : m_cnt + c;
            for (int i = 0; i < N; i++)
                if (debug_step[i] && !e_dbg[i]) dbg_s[i] = cyc + 1;
            m_dbgon = dbg_mode;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        job_valid = 1'b0;
        thread_busy = '0;
        thread_done = '0;
        dbg_mode = 1'b0;
        debug_step = '0;
        err_clear = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        tick();
        reset = 1'b0;
        en = 1'b1;
        tick();
        // Launch handshake
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        thread_busy[0] = 1'b1;
        repeat (8) tick();
        thread_done[0] = 1'b1;
        tick();
        thread_done = '0;
        thread_busy = '0;
        chk("tp1_done_count", done_count, 16'd1);
        chk("tp1_active", thread_active, 4'b0000);
        tick();
        // Fill all threads, stall, reopen on thread 2
        job_valid = 1'b1;
        repeat (5) tick();
        job_valid = 1'b0;
        chk("tp2_all_active", thread_active, 4'b1111);
        repeat (2) tick();
        thread_done[2] = 1'b1;
        tick();
        thread_done = '0;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("tp2_relaunch_t2", start_thread, 4'b0100);
        repeat (3) tick();
        thread_done = '1;
        tick();
        thread_done = '0;
        tick();
        // Timeout on thread 0, then clear
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        repeat (T + 2) tick();
        chk("tp3_err", timeout_err, 4'b0001);
        chk("tp3_idle", thread_active, 4'b0000);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("tp3_cleared", timeout_err, 4'b0000);
        tick();
        // Done in the timeout cycle wins
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        repeat (T) tick();
        thread_done[0] = 1'b1;
        tick();
        thread_done = '0;
        chk("tp4_no_err", timeout_err, 4'b0000);
        tick();
        // Timeout set beats a concurrent err_clear
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        repeat (T) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("tp4_set_wins", timeout_err, 4'b0001);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        // Two completions in one cycle
        job_valid = 1'b1;
        repeat (4) tick();
        job_valid = 1'b0;
        repeat (3) tick();
        thread_done = 4'b1010;
        tick();
        thread_done = '1;
        tick();
        thread_done = '0;
        tick();
        // Debug pulses and debug_on
        debug_step[1] = 1'b1;
        tick();
        debug_step = '0;
        tick();
        debug_step[1] = 1'b1;
        tick();
        debug_step = '0;
        repeat (2) tick();
        debug_step[1] = 1'b1;
        repeat (6) tick();
        debug_step = '0;
        dbg_mode = 1'b1;
        tick();
        tick();
        dbg_mode = 1'b0;
        tick();
        // Reset with three threads running, then en low
        job_valid = 1'b1;
        repeat (3) tick();
        job_valid = 1'b0;
        thread_busy = '1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        thread_busy = '0;
        tick();
        en = 1'b0;
        job_valid = 1'b1;
        repeat (10) tick();
        job_valid = 1'b0;
        en = 1'b1;
        // Random traffic: frequent completions, then rare ones so timeouts overlap
        for (int ph = 0; ph < 2; ph++) begin
            done_div = ph == 0 ? 8 : 1200;
            for (int k = 0; k < (ph == 0 ? 4000 : 3000); k++) begin
                reset = ph == 0 && $urandom_range(0, 499) == 0;
                en = $urandom_range(0, 9) != 0;
                job_valid = 1'($urandom_range(0, 1));
                thread_busy = N'($urandom);
                for (int i = 0; i < N; i++) begin
                    thread_done[i] = $urandom_range(0, done_div - 1) == 0;
                    debug_step[i] = $urandom_range(0, 3) == 0;
                end
                dbg_mode = 1'($urandom_range(0, 1));
                err_clear = $urandom_range(0, 19) == 0;
                tick();
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
